// File: rtl/forwarding_hazard_unit.sv
// Operand-bypass select generation and load-use stall detection for the 5-stage MIPS32 pipeline.
// Optional stall statistics counter is built when MIPS_HAZARD_STATS_EN is defined.
module forwarding_hazard_unit #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dest_reg,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            upper_ALU_mux_select_line,
    output logic [1:0]            lower_ALU_mux_select_line,
    output logic                  stall,
    output logic                  bubble,
    output logic [15:0]           stall_count
);

    localparam int unsigned SEL_W = 2;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  reg_write;
        logic                  mem_read;
    } ex_slot_t;

    // A load's result is forwardable once in MEM, so the MEM slot needs no load flag.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  reg_write;
    } mem_slot_t;

    ex_slot_t          ex_d, ex_q;
    mem_slot_t         mem_d, mem_q;
    logic [SEL_W-1:0]  upper_sel_d, upper_sel_q;
    logic [SEL_W-1:0]  lower_sel_d, lower_sel_q;
    logic              load_use_c;

    // Youngest matching producer wins; the code names the stage it occupies next cycle.
    function automatic logic [SEL_W-1:0] fwd_sel(
        input logic                  used,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  kill,
        input ex_slot_t              ex,
        input mem_slot_t             mem
    );
        logic [SEL_W-1:0] sel;
        sel = 2'b00;
        if (used && !kill && (src != '0)) begin
            if (ex.valid && ex.reg_write && (src == ex.dest)) begin
                sel = 2'b01;
            end else if (mem.valid && mem.reg_write && (src == mem.dest)) begin
                sel = 2'b10;
            end
        end
        return sel;
    endfunction

    always_comb begin
        load_use_c  = 1'b0;
        stall       = 1'b0;
        bubble      = 1'b0;
        ex_d        = '0;
        mem_d       = '0;
        upper_sel_d = 2'b00;
        lower_sel_d = 2'b00;

        load_use_c = ex_q.valid && ex_q.mem_read && (ex_q.dest != '0) &&
                     ((id_uses_rs && (id_rs == ex_q.dest)) ||
                      (id_uses_rt && (id_rt == ex_q.dest)));
        stall  = id_valid && !flush && load_use_c;
        bubble = stall || flush;

        if (id_valid && !bubble) begin
            ex_d.valid     = 1'b1;
            ex_d.dest      = id_dest_reg;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
        end

        mem_d.valid     = ex_q.valid;
        mem_d.dest      = ex_q.dest;
        mem_d.reg_write = ex_q.reg_write;

        upper_sel_d = fwd_sel(id_uses_rs, id_rs, bubble || !id_valid, ex_q, mem_q);
        lower_sel_d = fwd_sel(id_uses_rt, id_rt, bubble || !id_valid, ex_q, mem_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            upper_sel_q <= 2'b00;
            lower_sel_q <= 2'b00;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            upper_sel_q <= upper_sel_d;
            lower_sel_q <= lower_sel_d;
        end
    end

    assign upper_ALU_mux_select_line = upper_sel_q;
    assign lower_ALU_mux_select_line = lower_sel_q;

`ifdef MIPS_HAZARD_STATS_EN
    logic [15:0] stall_count_d, stall_count_q;

    // Saturating count of stalled cycles.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= 16'h0000;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed plus randomized bench for forwarding_hazard_unit against an in-flight-producer list model.
module tb_forwarding_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, flush;
    logic [4:0]  id_rs, id_rt, id_dest_reg;
    logic [1:0]  upper_sel, lower_sel;
    logic        stall, bubble;
    logic [15:0] stall_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    forwarding_hazard_unit #(.REG_ADDR_W(5)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .id_valid                  (id_valid),
        .id_rs                     (id_rs),
        .id_rt                     (id_rt),
        .id_uses_rs                (id_uses_rs),
        .id_uses_rt                (id_uses_rt),
        .id_dest_reg               (id_dest_reg),
        .id_reg_write              (id_reg_write),
        .id_mem_read               (id_mem_read),
        .flush                     (flush),
        .upper_ALU_mux_select_line (upper_sel),
        .lower_ALU_mux_select_line (lower_sel),
        .stall                     (stall),
        .bubble                    (bubble),
        .stall_count               (stall_count)
    );

    // In-flight instructions, youngest first: entry 0 is in EX, entry 1 is in MEM.
    typedef struct {
        bit       v;
        bit [4:0] d;
        bit       rw;
        bit       mr;
    } instr_t;

    instr_t   inflight[$];
    bit [1:0] exp_up, exp_lo;
    int       exp_cnt;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bypass code = 1 + pipeline position the youngest writer of r will hold next cycle.
    function automatic bit [1:0] model_sel(bit live, bit uses, bit [4:0] r);
        if (!live || !uses || r == 5'd0) return 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (inflight[i].v && inflight[i].rw && inflight[i].d == r) return 2'(i + 1);
        end
        return 2'b00;
    endfunction

    function automatic bit model_stall(bit v, bit fl, bit urs, bit [4:0] rs, bit urt, bit [4:0] rt);
        instr_t p;
        p = inflight[0];
        if (!v || fl || !p.v || !p.mr || p.d == 5'd0) return 1'b0;
        return (urs && rs == p.d) || (urt && rt == p.d);
    endfunction

    task automatic model_reset();
        instr_t e;
        e = '{v: 1'b0, d: 5'd0, rw: 1'b0, mr: 1'b0};
        inflight = {e, e};
        exp_up = 2'b00;
        exp_lo = 2'b00;
        exp_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_upper"}, 16'(upper_sel), 16'(exp_up));
        chk({tag, "_lower"}, 16'(lower_sel), 16'(exp_lo));
`ifdef MIPS_HAZARD_STATS_EN
        chk({tag, "_count"}, stall_count, 16'(exp_cnt));
`else
        chk({tag, "_count"}, stall_count, 16'h0000);
`endif
    endtask

    // One pipeline cycle: drive ID at negedge, check stall/bubble, then check registered results.
    task automatic cycle(input string tag, input bit v, input bit [4:0] rs, input bit urs,
                         input bit [4:0] rt, input bit urt, input bit [4:0] dest,
                         input bit rw, input bit mr, input bit fl);
        bit     es, eb;
        instr_t issued;
        @(negedge clk);
        id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_dest_reg = dest; id_reg_write = rw; id_mem_read = mr; flush = fl;
        #1;
        es = model_stall(v, fl, urs, rs, urt, rt);
        eb = es || fl;
        chk({tag, "_stall"}, 16'(stall), 16'(es));
        chk({tag, "_bubble"}, 16'(bubble), 16'(eb));
        exp_up = model_sel(v && !eb, urs, rs);
        exp_lo = model_sel(v && !eb, urt, rt);
        if (v && !eb) issued = '{v: 1'b1, d: dest, rw: rw, mr: mr};
        else          issued = '{v: 1'b0, d: 5'd0, rw: 1'b0, mr: 1'b0};
        @(posedge clk);
        if (es && exp_cnt < 16'hFFFF) exp_cnt++;
        inflight.push_front(issued);
        void'(inflight.pop_back());
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_dest_reg = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", 16'(stall), 16'd0);
        chk("reset_bubble", 16'(bubble), 16'd0);
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // add $3,$1,$2 ; sub $4,$3,$5
        cycle("add3", 1, 1, 1, 2, 1, 3, 1, 0, 0);
        cycle("sub4", 1, 3, 1, 5, 1, 4, 1, 0, 0);
        chk("sub_upper_const", 16'(upper_sel), 16'd1);
        chk("sub_lower_const", 16'(lower_sel), 16'd0);

        // add $3 ; nop ; or $6,$7,$3
        cycle("add3b", 1, 1, 1, 2, 1, 3, 1, 0, 0);
        cycle("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("or6", 1, 7, 1, 3, 1, 6, 1, 0, 0);
        chk("or_upper_const", 16'(upper_sel), 16'd0);
        chk("or_lower_const", 16'(lower_sel), 16'd2);

        // lw $8,0($9) ; add $10,$8,$8 (stalls once, then both operands from WB-side data)
        cycle("lw8", 1, 9, 1, 8, 0, 8, 1, 1, 0);
        cycle("add10_stall", 1, 8, 1, 8, 1, 10, 1, 0, 0);
        cycle("add10_go", 1, 8, 1, 8, 1, 10, 1, 0, 0);
        chk("add10_upper_const", 16'(upper_sel), 16'd2);
        chk("add10_lower_const", 16'(lower_sel), 16'd2);

        // addi $0,$1,5 ; add $2,$0,$0
        cycle("addi0", 1, 1, 1, 0, 0, 0, 1, 0, 0);
        cycle("add2", 1, 0, 1, 0, 1, 2, 1, 0, 0);
        chk("r0_upper_const", 16'(upper_sel), 16'd0);

        // lw $8 ; dependent add killed by flush in the same cycle
        cycle("lw8b", 1, 9, 1, 8, 0, 8, 1, 1, 0);
        cycle("add_flush", 1, 8, 1, 8, 1, 10, 1, 0, 1);
        chk("flush_upper_const", 16'(upper_sel), 16'd0);

        // Randomized traffic over a small register set to provoke many hazards.
        for (int n = 0; n < 400; n++) begin
            cycle("rand",
                  ($urandom_range(7) != 0), 5'($urandom_range(3)), 1'($urandom),
                  5'($urandom_range(3)), 1'($urandom), 5'($urandom_range(3)),
                  1'($urandom), 1'($urandom), ($urandom_range(7) == 0));
        end

        // Asynchronous reset while a load-use stall is being signalled.
        cycle("lw8c", 1, 9, 1, 8, 0, 8, 1, 1, 0);
        @(negedge clk);
        id_valid = 1; id_rs = 8; id_uses_rs = 1; id_rt = 8; id_uses_rt = 1;
        id_dest_reg = 10; id_reg_write = 1; id_mem_read = 0; flush = 0;
        #1;
        chk("pre_rst_stall", 16'(stall), 16'd1);
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_stall", 16'(stall), 16'd0);
        chk("async_rst_bubble", 16'(bubble), 16'd0);
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        cycle("post_rst", 1, 8, 1, 8, 1, 10, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
